// File: rtl/alu_arb_if.sv
// Bundles the alu_arb request, shared-ALU and response signals.
// slave = arbiter side, master = requester/ALU/consumer side.
interface alu_arb_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [2:0] req0_op;
  logic       req1_valid;
  logic       req1_ready;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [2:0] req1_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_mod;
  logic [3:0] alu_result;
  logic       alu_zero;
  logic       alu_c;
  logic       alu_ov;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_zero;
  logic       rsp_c;
  logic       rsp_ov;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_result, alu_zero, alu_c, alu_ov, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_mod,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_c, rsp_ov
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_result, alu_zero, alu_c, alu_ov, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_mod,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_c, rsp_ov
  );
endinterface

// File: rtl/alu_arb.sv
// Two-requester arbiter for a shared 4-bit ALU with a registered response.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arb #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_arb_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  logic [1:0] state;
  logic [2:0] cnt;
  logic       id_q;
  logic       grant_id;
  logic       any_valid;
  logic       xfer;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic       last_grant;
`endif

  always_comb begin
    any_valid = bus.req0_valid || bus.req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant_id  = !bus.req0_valid;
`else
    // On a tie the requester that did not win the last transfer goes next.
    grant_id  = (bus.req0_valid && bus.req1_valid) ? !last_grant : !bus.req0_valid;
`endif
  end

  assign bus.req0_ready = rst_n && (state == IDLE) && any_valid && !grant_id;
  assign bus.req1_ready = rst_n && (state == IDLE) && any_valid &&  grant_id;
  assign xfer           = (bus.req0_ready && bus.req0_valid) || (bus.req1_ready && bus.req1_valid);
  assign bus.rsp_valid  = (state == RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      id_q           <= 1'b0;
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_mod    <= '0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_c      <= 1'b0;
      bus.rsp_ov     <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            bus.alu_a   <= grant_id ? bus.req1_a  : bus.req0_a;
            bus.alu_b   <= grant_id ? bus.req1_b  : bus.req0_b;
            bus.alu_mod <= grant_id ? bus.req1_op : bus.req0_op;
            id_q        <= grant_id;
            cnt         <= LAT_INIT;
            state       <= EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant  <= grant_id;
`endif
          end
        end
        EXEC: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            bus.rsp_id     <= id_q;
            bus.rsp_result <= bus.alu_result;
            bus.rsp_zero   <= bus.alu_zero;
            bus.rsp_c      <= bus.alu_c;
            bus.rsp_ov     <= bus.alu_ov;
            state          <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb: one instance at ALU_LAT=1, one at ALU_LAT=3, each with a modelled ALU.
// Expected tie order follows ALU_ARB_FIXED_PRIO_EN when defined.
module tb_alu_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n;
  logic rst3_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_arb_if b1();
  alu_arb_if b3();

  alu_arb #(.ALU_LAT(1)) dut1 (.clk(clk), .rst_n(rst1_n), .bus(b1.slave));
  alu_arb #(.ALU_LAT(3)) dut3 (.clk(clk), .rst_n(rst3_n), .bus(b3.slave));

  // Reference ALU: 000 add, 001 sub (c = carry out of a + ~b + 1), 010 and, 011 or, else xor.
  function automatic logic [6:0] alu_model(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c;
    logic       ov;
    s  = '0;
    c  = 1'b0;
    ov = 1'b0;
    case (op)
      3'b000: begin
        s  = {1'b0, a} + {1'b0, b};
        r  = s[3:0];
        c  = s[4];
        ov = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'b001: begin
        s  = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r  = s[3:0];
        c  = s[4];
        ov = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      default: r = a ^ b;
    endcase
    return {r, (r == 4'h0), c, ov};
  endfunction

  always_comb {b1.alu_result, b1.alu_zero, b1.alu_c, b1.alu_ov} = alu_model(b1.alu_a, b1.alu_b, b1.alu_mod);
  always_comb {b3.alu_result, b3.alu_zero, b3.alu_c, b3.alu_ov} = alu_model(b3.alu_a, b3.alu_b, b3.alu_mod);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One LAT=1 transaction from a single requester, with rsp_ready held high.
  task automatic run_op1(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp_r, input logic ez, input logic ec, input logic eov,
                         input string tag);
    int lat;
    if (id == 1'b0) begin
      b1.req0_valid = 1'b1; b1.req0_op = op; b1.req0_a = a; b1.req0_b = b;
    end else begin
      b1.req1_valid = 1'b1; b1.req1_op = op; b1.req1_a = a; b1.req1_b = b;
    end
    #1;
    chk({tag, "_rdy0"}, b1.req0_ready, id == 1'b0);
    chk({tag, "_rdy1"}, b1.req1_ready, id == 1'b1);
    step;
    b1.req0_valid = 1'b0;
    b1.req1_valid = 1'b0;
    chk({tag, "_alu_a"}, b1.alu_a, a);
    chk({tag, "_alu_b"}, b1.alu_b, b);
    chk({tag, "_alu_mod"}, b1.alu_mod, op);
    lat = 1;
    while (!b1.rsp_valid && lat < 20) begin
      step;
      lat++;
    end
    chk({tag, "_lat"}, lat, 8'd2);
    chk({tag, "_id"}, b1.rsp_id, id);
    chk({tag, "_res"}, b1.rsp_result, exp_r);
    chk({tag, "_zero"}, b1.rsp_zero, ez);
    chk({tag, "_c"}, b1.rsp_c, ec);
    chk({tag, "_ov"}, b1.rsp_ov, eov);
    step;
    chk({tag, "_done"}, b1.rsp_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp_ids;
    int         seen;
    int         lat;
    int         c0;
    int         c1;
    int         nr;
    int         cyc;
    logic       g0;
    logic       g1;
    logic       eid;

    rst1_n = 1'b0;
    rst3_n = 1'b0;
    b1.req0_valid = 1'b1; b1.req0_a = '0; b1.req0_b = '0; b1.req0_op = '0;
    b1.req1_valid = 1'b1; b1.req1_a = '0; b1.req1_b = '0; b1.req1_op = '0;
    b1.rsp_ready  = 1'b1;
    b3.req0_valid = 1'b0; b3.req0_a = '0; b3.req0_b = '0; b3.req0_op = '0;
    b3.req1_valid = 1'b0; b3.req1_a = '0; b3.req1_b = '0; b3.req1_op = '0;
    b3.rsp_ready  = 1'b1;

    // Reset state, with both requesters asserting valid.
    step;
    step;
    #1;
    chk("rst_rdy0", b1.req0_ready, 1'b0);
    chk("rst_rdy1", b1.req1_ready, 1'b0);
    chk("rst_rsp_valid", b1.rsp_valid, 1'b0);
    chk("rst_alu_a", b1.alu_a, 4'h0);
    chk("rst_alu_b", b1.alu_b, 4'h0);
    chk("rst_alu_mod", b1.alu_mod, 3'b000);
    chk("rst_rsp_id", b1.rsp_id, 1'b0);
    chk("rst_rsp_res", b1.rsp_result, 4'h0);
    chk("rst_rsp_flags", {b1.rsp_zero, b1.rsp_c, b1.rsp_ov}, 3'b000);
    step;
    rst1_n = 1'b1;
    b1.req0_valid = 1'b0;
    b1.req1_valid = 1'b0;

    run_op1(1'b0, 3'b000, 4'd3, 4'd4, 4'd7, 1'b0, 1'b0, 1'b0, "add34");
    run_op1(1'b1, 3'b001, 4'd5, 4'd5, 4'd0, 1'b1, 1'b1, 1'b0, "sub55");

    // Response back-pressure for 5 cycles; a valid pulse during RESP must not transfer.
    b1.req0_valid = 1'b1; b1.req0_op = 3'b000; b1.req0_a = 4'd7; b1.req0_b = 4'd1;
    b1.rsp_ready  = 1'b0;
    #1;
    chk("hold_rdy0", b1.req0_ready, 1'b1);
    step;
    b1.req0_valid = 1'b0;
    step;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        b1.req0_valid = 1'b1;
        b1.req1_valid = 1'b1;
      end
      #1;
      chk("hold_valid", b1.rsp_valid, 1'b1);
      chk("hold_res", b1.rsp_result, 4'h8);
      chk("hold_ov", b1.rsp_ov, 1'b1);
      chk("hold_zc", {b1.rsp_zero, b1.rsp_c}, 2'b00);
      chk("hold_rdys", {b1.req0_ready, b1.req1_ready}, 2'b00);
      step;
      b1.req0_valid = 1'b0;
      b1.req1_valid = 1'b0;
    end
    b1.rsp_ready = 1'b1;
    #1;
    chk("hold_last", b1.rsp_valid, 1'b1);
    step;
    chk("hold_released", b1.rsp_valid, 1'b0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      step;
      if (b1.rsp_valid) seen++;
    end
    chk("pulse_no_rsp", seen, 8'd0);
    chk("pulse_no_xfer", b1.alu_a, 4'd7);

    // Both requesters valid from reset, four operations each.
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids = 8'b1111_0000;
`else
    exp_ids = 8'b1010_1010;
`endif
    rst1_n = 1'b0;
    step;
    rst1_n = 1'b1;
    b1.req0_op = 3'b000; b1.req0_a = 4'd1;  b1.req0_b = 4'd2;
    b1.req1_op = 3'b010; b1.req1_a = 4'hC;  b1.req1_b = 4'hA;
    b1.req0_valid = 1'b1;
    b1.req1_valid = 1'b1;
    c0 = 0; c1 = 0; nr = 0; cyc = 0;
    while (nr < 8 && cyc < 200) begin
      #1;
      g0 = b1.req0_valid && b1.req0_ready;
      g1 = b1.req1_valid && b1.req1_ready;
      step;
      cyc++;
      if (g0) begin c0++; if (c0 == 4) b1.req0_valid = 1'b0; end
      if (g1) begin c1++; if (c1 == 4) b1.req1_valid = 1'b0; end
      if (b1.rsp_valid) begin
        eid = exp_ids[nr];
        chk($sformatf("order_id%0d", nr), b1.rsp_id, eid);
        chk($sformatf("order_res%0d", nr), b1.rsp_result, eid ? 4'h8 : 4'h3);
        nr++;
      end
    end
    chk("order_count", nr, 8'd8);
    b1.req0_valid = 1'b0;
    b1.req1_valid = 1'b0;

    // ALU_LAT=3: reset during EXEC abandons the operation.
    rst3_n = 1'b1;
    b3.req0_valid = 1'b1; b3.req0_op = 3'b000; b3.req0_a = 4'd2; b3.req0_b = 4'd3;
    #1;
    chk("l3_rdy0", b3.req0_ready, 1'b1);
    step;
    b3.req0_valid = 1'b0;
    chk("l3_exec_alu_a", b3.alu_a, 4'd2);
    chk("l3_exec_rsp", b3.rsp_valid, 1'b0);
    step;
    rst3_n = 1'b0;
    step;
    rst3_n = 1'b1;
    chk("l3_rst_rsp", b3.rsp_valid, 1'b0);
    chk("l3_rst_alu_a", b3.alu_a, 4'h0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step;
      if (b3.rsp_valid) seen++;
    end
    chk("l3_abandoned", seen, 8'd0);
    b3.req0_valid = 1'b1; b3.req0_op = 3'b001; b3.req0_a = 4'd9; b3.req0_b = 4'd2;
    #1;
    chk("l3_rdy0_again", b3.req0_ready, 1'b1);
    step;
    b3.req0_valid = 1'b0;
    lat = 1;
    while (!b3.rsp_valid && lat < 20) begin
      step;
      lat++;
    end
    chk("l3_lat", lat, 8'd4);
    chk("l3_id", b3.rsp_id, 1'b0);
    chk("l3_res", b3.rsp_result, 4'd7);
    chk("l3_flags", {b3.rsp_zero, b3.rsp_c, b3.rsp_ov}, 3'b011);
    step;
    chk("l3_done", b3.rsp_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
